// File: rtl/led_share_arb.sv
// led_share_arb -- shares the single board LED among NREQ requesters.
//
// Each requester raises REQ with a pulse count on its CODE slice. A
// round-robin arbiter grants one requester at a time; the block then plays
// the blink code on ULED and pulses DONE for that requester at the end:
//   n pulses (ON_CYC high, OFF_CYC low between pulses), then GAP_CYC low.
// A code of 0 plays only the gap.
//
// Ports:
//   CLK   - system clock, rising edge
//   RST_X - synchronous active-low reset
//   REQ   - [NREQ] level requests, sampled only while idle
//   CODE  - [NREQ*CW] pulse counts, requester i at [i*CW +: CW]
//   GNT   - [NREQ] one-hot grant, registered
//   DONE  - [NREQ] one-cycle completion pulse, registered
//   BUSY  - sequence in progress
//   ULED  - LED drive, registered
//
// Optional build macro LED_SHARE_ARB_HEARTBEAT_EN: when defined, a 32-bit
// free-running counter drives ULED from bit HB_BIT while the block is idle.
module led_share_arb #(
   parameter int NREQ    = 4,
   parameter int CW      = 4,
   parameter int TW      = 16,
   parameter int ON_CYC  = 8,
   parameter int OFF_CYC = 8,
   parameter int GAP_CYC = 32,
   parameter int HB_BIT  = 23
) (
   input  logic                 CLK,
   input  logic                 RST_X,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ*CW-1:0]   CODE,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      DONE,
   output logic                 BUSY,
   output logic                 ULED
);

   localparam int PW = $clog2(NREQ);

   // Elaboration-time range checks.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("led_share_arb: NREQ must be 2..8");
   end
   if (ON_CYC < 1 || ON_CYC > (2**TW) - 1) begin : g_bad_on
      $error("led_share_arb: ON_CYC out of range");
   end
   if (OFF_CYC < 1 || OFF_CYC > (2**TW) - 1) begin : g_bad_off
      $error("led_share_arb: OFF_CYC out of range");
   end
   if (GAP_CYC < 1 || GAP_CYC > (2**TW) - 1) begin : g_bad_gap
      $error("led_share_arb: GAP_CYC out of range");
   end
   if (HB_BIT < 0 || HB_BIT > 31) begin : g_bad_hb
      $error("led_share_arb: HB_BIT must be 0..31");
   end

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t         state;
   logic [TW-1:0]  timer;
   logic [CW-1:0]  pulses;
   logic [PW-1:0]  ptr;
   logic           idle_led;

   logic           found;
   logic [PW-1:0]  win;
   logic [PW:0]    idx;
   logic [CW-1:0]  code_win;
   logic [CW-1:0]  pulses_dec;

`ifdef LED_SHARE_ARB_HEARTBEAT_EN
   logic [31:0] hb_cnt;

   always_ff @(posedge CLK) begin
      if (!RST_X) hb_cnt <= '0;
      else        hb_cnt <= hb_cnt + 32'd1;
   end

   assign idle_led = hb_cnt[HB_BIT];
`else
   assign idle_led = 1'b0;
`endif

   // Round-robin search: first set REQ bit strictly after ptr, with wrap.
   // idx is one bit wider than ptr so ptr+k cannot overflow before the wrap.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && REQ[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   assign code_win   = CODE[win*CW +: CW];
   assign pulses_dec = pulses - CW'(1);

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state  <= IDLE;
         GNT    <= '0;
         DONE   <= '0;
         BUSY   <= 1'b0;
         ULED   <= 1'b0;
         timer  <= '0;
         pulses <= '0;
         ptr    <= PW'(NREQ-1);
      end else begin
         DONE <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  GNT    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                  BUSY   <= 1'b1;
                  ptr    <= win;
                  pulses <= code_win;
                  if (code_win != '0) begin
                     state <= ON;
                     ULED  <= 1'b1;
                     timer <= TW'(ON_CYC-1);
                  end else begin
                     state <= GAP;
                     ULED  <= 1'b0;
                     timer <= TW'(GAP_CYC-1);
                  end
               end else begin
                  ULED <= idle_led;
               end
            end
            ON: begin
               if (timer == '0) begin
                  pulses <= pulses_dec;
                  ULED   <= 1'b0;
                  // Last pulse goes straight to the inter-code gap.
                  if (pulses_dec != '0) begin
                     state <= OFF;
                     timer <= TW'(OFF_CYC-1);
                  end else begin
                     state <= GAP;
                     timer <= TW'(GAP_CYC-1);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            OFF: begin
               if (timer == '0) begin
                  state <= ON;
                  ULED  <= 1'b1;
                  timer <= TW'(ON_CYC-1);
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            GAP: begin
               if (timer == '0) begin
                  state <= IDLE;
                  GNT   <= '0;
                  BUSY  <= 1'b0;
                  DONE  <= GNT;   // GNT still holds the winner's one-hot
                  ULED  <= idle_led;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/led_share_arb.md
Name: led_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single board LED (ULED) among NREQ requesters.
- Each requester asks to show a blink code: N pulses, then an inter-code gap.
- The block grants one requester at a time, drives the LED pulse train itself, and signals completion.
- It sits between status sources (reset monitor, error flags, heartbeat logic) and the ULED pin.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 4, width of each requester's pulse-count code.
- TW, 16, width of the phase timer.
- ON_CYC, 8, LED-high cycles per pulse (1..2^TW-1).
- OFF_CYC, 8, LED-low cycles between pulses (1..2^TW-1).
- GAP_CYC, 32, LED-low cycles after the last pulse (1..2^TW-1).
- HB_BIT, 23, free-running counter bit used for the heartbeat (optional feature only).

Ports:
- CLK, input, 1, system clock; all logic on the rising edge.
- RST_X, input, 1, synchronous active-low reset.
- REQ, input, NREQ, level request per requester.
- CODE, input, NREQ*CW, pulse count; requester i uses bits [i*CW +: CW].
- GNT, output, NREQ, one-hot grant, registered.
- DONE, output, NREQ, one-cycle completion pulse for the granted requester, registered.
- BUSY, output, 1, high while a sequence is in progress.
- ULED, output, 1, LED drive, registered.

Behaviour:
- Reset: RST_X low at a clock edge forces:
  - state=IDLE, GNT=0, DONE=0, BUSY=0, ULED=0, timer=0, pulse counter=0;
  - round-robin pointer=NREQ-1, so requester 0 has first priority.
  - Reset mid-sequence aborts at once; no DONE is issued.
- States: IDLE, ON, OFF, GAP.
- IDLE, arbitration:
  - If any REQ bit is high, grant the first set bit searching upward from pointer+1 with wrap-around.
  - Latch that requester's CODE into the pulse counter and set pointer to the winner.
  - Next cycle: GNT one-hot, BUSY=1.
  - Latched code != 0: enter ON with ULED=1. Latched code == 0: enter GAP with ULED=0.
  - REQ-to-ULED latency is 1 cycle.
- ON:
  - ULED=1 for exactly ON_CYC cycles.
  - Then decrement the pulse counter. If the result is nonzero, go to OFF; else go to GAP.
- OFF: ULED=0 for exactly OFF_CYC cycles, then return to ON.
- GAP: ULED=0 for exactly GAP_CYC cycles, then return to IDLE.
- Leaving GAP, in the same edge:
  - GNT returns to 0 and BUSY returns to 0.
  - DONE[winner]=1 for one cycle.
- Back-to-back requests: the next grant is arbitrated in that IDLE cycle, so there is exactly 1 idle cycle between sequences.
- Total GNT-high duration for code n>0: n*ON_CYC + (n-1)*OFF_CYC + GAP_CYC cycles. For n=0 it is GAP_CYC.
- REQ and CODE are ignored while BUSY. Deasserting REQ mid-sequence does not abort; the sequence completes and DONE still fires.
- Timer: loads phase length minus 1 on phase entry and counts down to 0. No wrap in range; parameters are checked at elaboration.
- The pointer is updated only on a grant. A requester holding REQ continuously is re-granted only after every other active requester has been served.

Optional Feature:
- Macro: LED_SHARE_ARB_HEARTBEAT_EN
- Defined:
  - A TW-independent 32-bit free-running counter is added; it increments every cycle and resets to 0.
  - In IDLE, ULED = counter[HB_BIT].
  - In ON/OFF/GAP, ULED follows the sequence as above.
- Undefined: no counter is built and ULED=0 in IDLE.

Test Plan (ON_CYC=2, OFF_CYC=3, GAP_CYC=4, NREQ=4, CW=4; heartbeat undefined unless stated):
- Reset, then REQ=0001 with CODE0=3 -> ULED sequence 1,1,0,0,0,1,1,0,0,0,1,1,0,0,0,0; GNT=0001 for 16 cycles; DONE=0001 on cycle 17; BUSY low that cycle.
- REQ=1111 held, all codes=1 -> grants in order 0001, 0010, 0100, 1000, 0001; each GNT lasts 6 cycles, with 1 idle cycle between grants.
- REQ=0100 with CODE2=0 -> ULED stays 0; GNT=0100 for 4 cycles; DONE=0100 follows.
- REQ=0010 with CODE1=2, REQ dropped after 1 cycle, CODE1 changed to 5 mid-sequence -> still exactly 2 pulses (11 GNT cycles); DONE fires.
- RST_X low for 1 cycle during the second ON phase -> next cycle GNT=0, ULED=0, BUSY=0, no DONE; a new REQ=0001 is granted before requester 2.
- Heartbeat defined, HB_BIT=2, idle -> ULED toggles every 4 cycles; a request overrides it with a 1-cycle latency.
